// File: rtl/count_sequence_checker.sv
// ---------------------------------------------------------------------------
// CountSequenceChecker (module count_sequence_checker)
//
// Receive-side monitor for a free-running up-counter stream. It samples the
// count word on every valid cycle and locks onto the +1 mod 2^WIDTH sequence.
// Once locked, it flags sequence breaks, counts wraps and errors, and drops
// lock after ERR_LIMIT consecutive misses.
//
// Optional feature macro: HOLD_TOLERANT_EN
//    When defined, a valid sample that repeats the previous sample
//    (count_in == expected-1) in SYNC or LOCKED is treated as a hold. A hold
//    changes no state and produces no pulse. When undefined, a repeated
//    sample is an ordinary mismatch.
//
// Ports:
//    clock       in   system clock, rising edge
//    reset       in   asynchronous reset, active-high
//    in_valid    in   count_in carries a valid sample this cycle
//    count_in    in   sampled counter value (WIDTH bits)
//    locked      out  high while the FSM is in LOCKED
//    error       out  one-cycle pulse on a mismatch while LOCKED
//    wrap        out  one-cycle pulse when a correct sample equals 0 while LOCKED
//    wrap_count  out  wraps seen, modulo 2^WRAP_CNT_W
//    err_count   out  mismatches seen while LOCKED, saturating at 255
// ---------------------------------------------------------------------------
module count_sequence_checker #(
   parameter int WIDTH      = 4,
   parameter int LOCK_LEN   = 2,
   parameter int ERR_LIMIT  = 3,
   parameter int WRAP_CNT_W = 8
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  in_valid,
   input  logic [WIDTH-1:0]      count_in,
   output logic                  locked,
   output logic                  error,
   output logic                  wrap,
   output logic [WRAP_CNT_W-1:0] wrap_count,
   output logic [7:0]            err_count
);

   localparam logic [3:0] LOCK_LEN_C  = 4'(LOCK_LEN);
   localparam logic [3:0] ERR_LIMIT_C = 4'(ERR_LIMIT);

   typedef enum logic [1:0] {
      UNLOCKED = 2'd0,
      SYNC     = 2'd1,
      LOCKED   = 2'd2
   } state_t;

   state_t                r_state;
   state_t                w_stateNext;
   logic [WIDTH-1:0]      r_expected;
   logic [WIDTH-1:0]      w_expectedNext;
   logic [3:0]            r_run;
   logic [3:0]            w_runNext;
   logic [3:0]            r_miss;
   logic [3:0]            w_missNext;
   logic                  r_error;
   logic                  w_errorNext;
   logic                  r_wrap;
   logic                  w_wrapNext;
   logic [WRAP_CNT_W-1:0] r_wrapCount;
   logic [WRAP_CNT_W-1:0] w_wrapCountNext;
   logic [7:0]            r_errCount;
   logic [7:0]            w_errCountNext;

   logic                  w_match;
   logic                  w_hold;
   logic [WIDTH-1:0]      w_rebase;
   logic [3:0]            w_runInc;
   logic [3:0]            w_missInc;

   // The value the next sample must carry if the stream is intact; the
   // natural WIDTH-bit overflow makes all-ones followed by 0 a match.
   assign w_match   = (count_in == r_expected);
   assign w_rebase  = WIDTH'(count_in + 1'b1);
   assign w_runInc  = r_run + 4'd1;
   assign w_missInc = r_miss + 4'd1;

   // A hold is a repeat of the previous sample, which is always expected-1
   // because expected is rebuilt from every accepted sample.
`ifdef HOLD_TOLERANT_EN
   assign w_hold = (count_in == WIDTH'(r_expected - 1'b1));
`else
   assign w_hold = 1'b0;
`endif

   // State register: every piece of state, including the output pulses and
   // counters, is registered so the response to a sample appears right after
   // the edge that took it.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state     <= UNLOCKED;
         r_expected  <= '0;
         r_run       <= '0;
         r_miss      <= '0;
         r_error     <= 1'b0;
         r_wrap      <= 1'b0;
         r_wrapCount <= '0;
         r_errCount  <= '0;
      end else begin
         r_state     <= w_stateNext;
         r_expected  <= w_expectedNext;
         r_run       <= w_runNext;
         r_miss      <= w_missNext;
         r_error     <= w_errorNext;
         r_wrap      <= w_wrapNext;
         r_wrapCount <= w_wrapCountNext;
         r_errCount  <= w_errCountNext;
      end
   end

   // Next-state logic. Pulses default low so an idle cycle (in_valid=0) or
   // a hold produces no error/wrap and leaves all other state untouched.
   // In SYNC a mismatch rebases on the new sample instead of flagging, since
   // nothing has been trusted yet. In LOCKED a mismatch also resyncs to the
   // new sample, so a single glitch costs exactly one error pulse.
   always_comb begin
      w_stateNext     = r_state;
      w_expectedNext  = r_expected;
      w_runNext       = r_run;
      w_missNext      = r_miss;
      w_errorNext     = 1'b0;
      w_wrapNext      = 1'b0;
      w_wrapCountNext = r_wrapCount;
      w_errCountNext  = r_errCount;

      if (in_valid) begin
         case (r_state)
            UNLOCKED: begin
               w_expectedNext = w_rebase;
               w_runNext      = '0;
               w_stateNext    = SYNC;
            end

            SYNC: begin
               if (!w_hold) begin
                  w_expectedNext = w_rebase;
                  if (w_match) begin
                     w_runNext = w_runInc;
                     if (w_runInc == LOCK_LEN_C) begin
                        w_stateNext = LOCKED;
                        w_missNext  = '0;
                     end
                  end else begin
                     w_runNext = '0;
                  end
               end
            end

            LOCKED: begin
               if (!w_hold) begin
                  w_expectedNext = w_rebase;
                  if (w_match) begin
                     w_missNext = '0;
                     if (count_in == '0) begin
                        w_wrapNext      = 1'b1;
                        w_wrapCountNext = r_wrapCount + 1'b1;
                     end
                  end else begin
                     w_errorNext = 1'b1;
                     if (r_errCount != 8'hFF) begin
                        w_errCountNext = r_errCount + 8'd1;
                     end
                     w_missNext = w_missInc;
                     if (w_missInc == ERR_LIMIT_C) begin
                        w_stateNext = UNLOCKED;
                        w_runNext   = '0;
                     end
                  end
               end
            end

            default: begin
               w_stateNext = UNLOCKED;
            end
         endcase
      end
   end

   assign locked     = (r_state == LOCKED);
   assign error      = r_error;
   assign wrap       = r_wrap;
   assign wrap_count = r_wrapCount;
   assign err_count  = r_errCount;

endmodule

// File: tb/tb_count_sequence_checker.sv
// ---------------------------------------------------------------------------
// Testbench for count_sequence_checker (default parameters).
//
// Stimulus is driven on the falling edge; for every driven cycle the
// hand-computed expected outputs are pushed into a queue. A separate monitor
// pops one entry shortly after each rising edge and compares all outputs.
// Expectations for the repeated-sample scenario depend on HOLD_TOLERANT_EN.
// ---------------------------------------------------------------------------
module tb_count_sequence_checker;

   typedef struct packed {
      logic       locked;
      logic       error;
      logic       wrap;
      logic [7:0] wrapCount;
      logic [7:0] errCount;
   } expect_t;

   logic       clock;
   logic       reset;
   logic       inValid;
   logic [3:0] countIn;
   logic       locked;
   logic       error;
   logic       wrap;
   logic [7:0] wrapCount;
   logic [7:0] errCount;

   expect_t    scoreQ[$];
   int         checkCount = 0;
   int         errorCount = 0;

   count_sequence_checker #(
      .WIDTH      (4),
      .LOCK_LEN   (2),
      .ERR_LIMIT  (3),
      .WRAP_CNT_W (8)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .in_valid   (inValid),
      .count_in   (countIn),
      .locked     (locked),
      .error      (error),
      .wrap       (wrap),
      .wrap_count (wrapCount),
      .err_count  (errCount)
   );

   // Free-running clock, 10 time units per period.
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string name, input logic [7:0] actual,
                              input logic [7:0] expected);
      checkCount++;
      if (actual !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
      end
   endtask

   // Drives one sample on the falling edge and queues what the DUT should
   // show right after the following rising edge.
   task automatic applyStimulus(input logic v, input logic [3:0] value,
                                input logic eLocked, input logic eError,
                                input logic eWrap, input logic [7:0] eWrapCount,
                                input logic [7:0] eErrCount);
      expect_t e;
      @(negedge clock);
      inValid     = v;
      countIn     = value;
      e.locked    = eLocked;
      e.error     = eError;
      e.wrap      = eWrap;
      e.wrapCount = eWrapCount;
      e.errCount  = eErrCount;
      scoreQ.push_back(e);
   endtask

   // Checks that all outputs read zero right now (used during reset).
   task automatic checkResetState(input string tag);
      checkOutput({tag, "_locked"},    {7'd0, locked}, 8'd0);
      checkOutput({tag, "_error"},     {7'd0, error},  8'd0);
      checkOutput({tag, "_wrap"},      {7'd0, wrap},   8'd0);
      checkOutput({tag, "_wrapCount"}, wrapCount,      8'd0);
      checkOutput({tag, "_errCount"},  errCount,       8'd0);
   endtask

   // Monitor: compares the DUT against the oldest queued expectation shortly
   // after each rising edge, independent of the stimulus process.
   initial begin
      expect_t e;
      forever begin
         @(posedge clock);
         #1;
         if (scoreQ.size() != 0) begin
            e = scoreQ.pop_front();
            checkOutput("locked",    {7'd0, locked}, {7'd0, e.locked});
            checkOutput("error",     {7'd0, error},  {7'd0, e.error});
            checkOutput("wrap",      {7'd0, wrap},   {7'd0, e.wrap});
            checkOutput("wrapCount", wrapCount,      e.wrapCount);
            checkOutput("errCount",  errCount,       e.errCount);
         end
      end
   end

   initial begin
      int expEc;
      reset   = 1'b1;
      inValid = 1'b0;
      countIn = 4'd0;
      #12;
      checkResetState("reset");
      @(negedge clock);
      reset = 1'b0;

      // Lock-in: base 0, then two matches lock on the third sample.
      applyStimulus(1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
      applyStimulus(1'b1, 4'd1, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
      applyStimulus(1'b1, 4'd2, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0);
      for (int v = 3; v <= 13; v++)
         applyStimulus(1'b1, 4'(v), 1'b1, 1'b0, 1'b0, 8'd0, 8'd0);

      // Wrap: 14,15,0,1 pulses wrap once on 0; 16 more samples wrap again.
      applyStimulus(1'b1, 4'd14, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0);
      applyStimulus(1'b1, 4'd15, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0);
      applyStimulus(1'b1, 4'd0,  1'b1, 1'b0, 1'b1, 8'd1, 8'd0);
      applyStimulus(1'b1, 4'd1,  1'b1, 1'b0, 1'b0, 8'd1, 8'd0);
      for (int i = 2; i <= 17; i++)
         applyStimulus(1'b1, 4'(i % 16), 1'b1, 1'b0, (i == 16),
                       (i >= 16) ? 8'd2 : 8'd1, 8'd0);

      // Single glitch: 5,6,9,10,11 gives one error at 9 and stays locked.
      applyStimulus(1'b1, 4'd2,  1'b1, 1'b0, 1'b0, 8'd2, 8'd0);
      applyStimulus(1'b1, 4'd3,  1'b1, 1'b0, 1'b0, 8'd2, 8'd0);
      applyStimulus(1'b1, 4'd4,  1'b1, 1'b0, 1'b0, 8'd2, 8'd0);
      applyStimulus(1'b1, 4'd5,  1'b1, 1'b0, 1'b0, 8'd2, 8'd0);
      applyStimulus(1'b1, 4'd6,  1'b1, 1'b0, 1'b0, 8'd2, 8'd0);
      applyStimulus(1'b1, 4'd9,  1'b1, 1'b1, 1'b0, 8'd2, 8'd1);
      applyStimulus(1'b1, 4'd10, 1'b1, 1'b0, 1'b0, 8'd2, 8'd1);
      applyStimulus(1'b1, 4'd11, 1'b1, 1'b0, 1'b0, 8'd2, 8'd1);

      // Unlock: after ...,3 the samples 7,2,12 are three misses in a row;
      // lock drops with the third error, then 13,14,15 relock.
      applyStimulus(1'b1, 4'd12, 1'b1, 1'b0, 1'b0, 8'd2, 8'd1);
      applyStimulus(1'b1, 4'd13, 1'b1, 1'b0, 1'b0, 8'd2, 8'd1);
      applyStimulus(1'b1, 4'd14, 1'b1, 1'b0, 1'b0, 8'd2, 8'd1);
      applyStimulus(1'b1, 4'd15, 1'b1, 1'b0, 1'b0, 8'd2, 8'd1);
      applyStimulus(1'b1, 4'd0,  1'b1, 1'b0, 1'b1, 8'd3, 8'd1);
      applyStimulus(1'b1, 4'd1,  1'b1, 1'b0, 1'b0, 8'd3, 8'd1);
      applyStimulus(1'b1, 4'd2,  1'b1, 1'b0, 1'b0, 8'd3, 8'd1);
      applyStimulus(1'b1, 4'd3,  1'b1, 1'b0, 1'b0, 8'd3, 8'd1);
      applyStimulus(1'b1, 4'd7,  1'b1, 1'b1, 1'b0, 8'd3, 8'd2);
      applyStimulus(1'b1, 4'd2,  1'b1, 1'b1, 1'b0, 8'd3, 8'd3);
      applyStimulus(1'b1, 4'd12, 1'b0, 1'b1, 1'b0, 8'd3, 8'd4);
      applyStimulus(1'b1, 4'd13, 1'b0, 1'b0, 1'b0, 8'd3, 8'd4);
      applyStimulus(1'b1, 4'd14, 1'b0, 1'b0, 1'b0, 8'd3, 8'd4);
      applyStimulus(1'b1, 4'd15, 1'b1, 1'b0, 1'b0, 8'd3, 8'd4);

      // Idle gap: five invalid cycles carrying junk change nothing.
      for (int i = 0; i < 5; i++)
         applyStimulus(1'b0, 4'd9, 1'b1, 1'b0, 1'b0, 8'd3, 8'd4);
      applyStimulus(1'b1, 4'd0, 1'b1, 1'b0, 1'b1, 8'd4, 8'd4);
      applyStimulus(1'b1, 4'd1, 1'b1, 1'b0, 1'b0, 8'd4, 8'd4);
      applyStimulus(1'b1, 4'd2, 1'b1, 1'b0, 1'b0, 8'd4, 8'd4);
      applyStimulus(1'b1, 4'd3, 1'b1, 1'b0, 1'b0, 8'd4, 8'd4);

      // Asynchronous reset between edges clears every output at once.
      @(negedge clock);
      inValid = 1'b0;
      reset   = 1'b1;
      #1;
      checkResetState("asyncReset");
      @(negedge clock);
      reset = 1'b0;

      // Repeated samples 4,5,5,5,6: holds with the macro, errors without.
      applyStimulus(1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
      applyStimulus(1'b1, 4'd1, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
      applyStimulus(1'b1, 4'd2, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0);
      applyStimulus(1'b1, 4'd3, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0);
      applyStimulus(1'b1, 4'd4, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0);
      applyStimulus(1'b1, 4'd5, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0);
`ifdef HOLD_TOLERANT_EN
      applyStimulus(1'b1, 4'd5, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0);
      applyStimulus(1'b1, 4'd5, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0);
      applyStimulus(1'b1, 4'd6, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0);
`else
      applyStimulus(1'b1, 4'd5, 1'b1, 1'b1, 1'b0, 8'd0, 8'd1);
      applyStimulus(1'b1, 4'd5, 1'b1, 1'b1, 1'b0, 8'd0, 8'd2);
      applyStimulus(1'b1, 4'd6, 1'b1, 1'b0, 1'b0, 8'd0, 8'd2);
`endif

      // Saturation: repeated lock / three-miss rounds push err_count past
      // 255; it must stick there.
      @(negedge clock);
      inValid = 1'b0;
      reset   = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      expEc = 0;
      for (int r = 0; r < 86; r++) begin
         applyStimulus(1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 8'd0, 8'(expEc));
         applyStimulus(1'b1, 4'd1, 1'b0, 1'b0, 1'b0, 8'd0, 8'(expEc));
         applyStimulus(1'b1, 4'd2, 1'b1, 1'b0, 1'b0, 8'd0, 8'(expEc));
         expEc = (expEc < 255) ? expEc + 1 : 255;
         applyStimulus(1'b1, 4'd9, 1'b1, 1'b1, 1'b0, 8'd0, 8'(expEc));
         expEc = (expEc < 255) ? expEc + 1 : 255;
         applyStimulus(1'b1, 4'd7, 1'b1, 1'b1, 1'b0, 8'd0, 8'(expEc));
         expEc = (expEc < 255) ? expEc + 1 : 255;
         applyStimulus(1'b1, 4'd5, 1'b0, 1'b1, 1'b0, 8'd0, 8'(expEc));
      end

      // Drain the scoreboard with a bounded wait.
      @(negedge clock);
      inValid = 1'b0;
      for (int i = 0; i < 10 && scoreQ.size() != 0; i++)
         @(negedge clock);
      checkCount++;
      if (scoreQ.size() != 0) begin
         errorCount++;
         $display("[TB] FAIL drain: %0d entries left, expected 0", scoreQ.size());
      end

      $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
      $finish;
   end

endmodule
